seg7_capture: RTL and testbench

Sequential seven-segment bus reader: samples a time-multiplexed, active-low segment/anode bus (as driven toward the 4-digit display), waits for each digit pattern to settle, and decodes it back to a 4-bit value per digit position. It is the receive end of the segment encoder path. Its uses are self-checking on-board loopback of the adder display and readback of the display state by downstream logic. It also flags illegal segment patterns.

---
 rtl/seg7_capture.sv | 158 +++++++++++++++
 tb/tb_seg7_capture.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Receive end of the seven-segment display path: synchronizes the multiplexed active-low
// segment/anode bus, waits for each pattern to settle and decodes it per digit.
// Build option SEG7_CAPTURE_HEX_EN: also accept the six hex letter patterns A..F.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] digit_val,
    output logic [3:0]  digit_ok,
    output logic        digit_valid,
    output logic [1:0]  digit_idx,
    output logic        err,
    output logic        frame_valid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [10:0]   sync1, sync2, sync_prev;
    logic [CW-1:0] run_cnt, run_cnt_next;
    logic          changed, evt;
    logic          cap_evt;
    logic [10:0]   cap_pat;
    logic [3:0]    mask;

    logic [15:0] val_n;
    logic [3:0]  ok_n, mask_n, merged;
    logic [1:0]  idx_n, sel_idx;
    logic        valid_n, err_n, frame_n, sel, hit;
    logic [3:0]  dec_val;

    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
`ifdef SEG7_CAPTURE_HEX_EN
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
`endif
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    // Stage registers reset to all-ones: blank segments, no digit selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '1;
            sync2     <= '1;
            sync_prev <= '1;
        end else begin
            sync1     <= {an_in, seg_in};
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // The (changed || not yet saturated) term keeps one event per run even when STABLE_CYCLES=1.
    always_comb begin
        changed = (sync2 != sync_prev);
        if (changed)
            run_cnt_next = CNT_ONE;
        else if (run_cnt == CNT_MAX)
            run_cnt_next = run_cnt;
        else
            run_cnt_next = run_cnt + CNT_ONE;
        evt = (run_cnt_next == CNT_MAX) && (changed || (run_cnt != CNT_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
            cap_evt <= 1'b0;
            cap_pat <= '1;
        end else begin
            run_cnt <= run_cnt_next;
            cap_evt <= evt;
            cap_pat <= sync2;
        end
    end

    always_comb begin
        val_n   = digit_val;
        ok_n    = digit_ok;
        idx_n   = digit_idx;
        mask_n  = mask;
        merged  = mask;
        valid_n = 1'b0;
        err_n   = 1'b0;
        frame_n = 1'b0;
        sel     = 1'b1;
        sel_idx = 2'd0;
        {hit, dec_val} = decode(cap_pat[6:0]);
        case (cap_pat[10:7])
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel     = 1'b0;
        endcase
        if (cap_evt && sel) begin
            idx_n = sel_idx;
            if (hit) begin
                val_n[{sel_idx, 2'b00} +: 4] = dec_val;
                ok_n[sel_idx] = 1'b1;
                valid_n = 1'b1;
                merged  = mask | (4'b0001 << sel_idx);
                if (merged == 4'b1111) begin
                    frame_n = 1'b1;
                    mask_n  = 4'b0000;
                end else begin
                    mask_n  = merged;
                end
            end else begin
                err_n = 1'b1;
                ok_n[sel_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_val   <= 16'h0000;
            digit_ok    <= 4'b0000;
            digit_valid <= 1'b0;
            digit_idx   <= 2'd0;
            err         <= 1'b0;
            frame_valid <= 1'b0;
            mask        <= 4'b0000;
        end else begin
            digit_val   <= val_n;
            digit_ok    <= ok_n;
            digit_valid <= valid_n;
            digit_idx   <= idx_n;
            err         <= err_n;
            frame_valid <= frame_n;
            mask        <= mask_n;
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios plus random bus traffic, every cycle compared
// against a run-length reference model over the history of driven bus values.
module tb_seg7_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = 7'h7f;
    logic [3:0]  an_in = 4'hf;
    logic [15:0] digit_val;
    logic [3:0]  digit_ok;
    logic        digit_valid;
    logic [1:0]  digit_idx;
    logic        err;
    logic        frame_valid;

    seg7_capture #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
        .digit_val(digit_val), .digit_ok(digit_ok), .digit_valid(digit_valid),
        .digit_idx(digit_idx), .err(err), .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad = 0;

    logic [6:0]  tbl [16];
    int          n_legal;
    logic [10:0] hist [$];

    logic [15:0] e_val;
    logic [3:0]  e_ok, e_mask;
    logic [1:0]  e_idx;
    logic        e_valid, e_err, e_frame;

    int n_valid, n_err, n_frame, first_valid;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", tag, hist.size(), obs, exp);
        end
    endtask

    function automatic logic [10:0] hget(input int k);
        if (k < 0 || k >= hist.size()) return 11'h7ff;
        return hist[k];
    endfunction

    task automatic apply_event(input logic [10:0] v);
        int nlow = 0;
        int d = 0;
        int found = -1;
        for (int i = 0; i < 4; i++)
            if (!v[7+i]) begin
                nlow++;
                d = i;
            end
        if (nlow != 1) return;
        e_idx = 2'(d);
        for (int j = 0; j < n_legal; j++)
            if (tbl[j] == v[6:0]) found = j;
        if (found >= 0) begin
            e_val[d*4 +: 4] = 4'(found);
            e_ok[d]   = 1'b1;
            e_valid   = 1'b1;
            e_mask[d] = 1'b1;
            if (e_mask == 4'hf) begin
                e_frame = 1'b1;
                e_mask  = 4'h0;
            end
        end else begin
            e_err   = 1'b1;
            e_ok[d] = 1'b0;
        end
    endtask

    // A capture shows up after edge c when the S samples ending at edge c-3 agree and
    // the sample just before them differs (new run).
    task automatic model_step();
        int c = hist.size() - 1;
        logic [10:0] v;
        logic stable;
        e_valid = 1'b0;
        e_err   = 1'b0;
        e_frame = 1'b0;
        if (c - S - 2 >= 0) begin
            v = hget(c - S - 2);
            stable = 1'b1;
            for (int k = c - S - 1; k <= c - 3; k++)
                if (hget(k) != v) stable = 1'b0;
            if (stable && hget(c - S - 3) != v) apply_event(v);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        e_val = '0; e_ok = '0; e_mask = '0; e_idx = '0;
        e_valid = 0; e_err = 0; e_frame = 0;
    endtask

    task automatic step(input logic [3:0] an, input logic [6:0] seg);
        an_in  = an;
        seg_in = seg;
        @(posedge clk);
        hist.push_back({an, seg});
        model_step();
        @(negedge clk);
        check_val("outputs",
            {7'd0, digit_val, digit_ok, digit_valid, digit_idx, err, frame_valid},
            {7'd0, e_val, e_ok, e_valid, e_idx, e_err, e_frame});
        if (digit_valid) begin
            n_valid++;
            if (first_valid < 0) first_valid = hist.size() - 1;
        end
        if (err) n_err++;
        if (frame_valid) n_frame++;
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        for (int i = 0; i < n; i++) step(an, seg);
    endtask

    task automatic clear_counts();
        n_valid = 0; n_err = 0; n_frame = 0; first_valid = -1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_val("reset_outs",
            {7'd0, digit_val, digit_ok, digit_valid, digit_idx, err, frame_valid}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] an;
        logic [6:0] seg;
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
                7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
`ifdef SEG7_CAPTURE_HEX_EN
        n_legal = 16;
`else
        n_legal = 10;
`endif
        model_reset();
        @(negedge clk);
        do_reset();

        // Single capture and its latency.
        clear_counts();
        hold(4'b1110, 7'b0010010, 10);
        check_val("t1_count", 32'(n_valid), 32'd1);
        check_val("t1_latency", 32'(first_valid), 32'd6);
        check_val("t1_val", {28'd0, digit_val[3:0]}, 32'd2);
        check_val("t1_ok", {28'd0, digit_ok}, 32'b0001);

        // Scan 1,2,3,4 across digits 0..3.
        clear_counts();
        hold(4'b1110, tbl[1], 8);
        hold(4'b1101, tbl[2], 8);
        hold(4'b1011, tbl[3], 8);
        hold(4'b0111, tbl[4], 8);
        check_val("scan_valid", 32'(n_valid), 32'd4);
        check_val("scan_frame", 32'(n_frame), 32'd1);
        check_val("scan_val", {16'd0, digit_val}, 32'h4321);
        check_val("scan_ok", {28'd0, digit_ok}, 32'hf);

        // Blank pattern on digit 3 is illegal.
        clear_counts();
        hold(4'b0111, 7'b1111111, 8);
        check_val("blank_err", 32'(n_err), 32'd1);
        check_val("blank_idx", {30'd0, digit_idx}, 32'd3);
        check_val("blank_nib", {28'd0, digit_val[15:12]}, 32'd4);
        check_val("blank_ok", {28'd0, digit_ok}, 32'b0111);

        // Glitch inside the stability window.
        clear_counts();
        hold(4'b1101, tbl[7], 3);
        hold(4'b1101, 7'b0000000, 2);
        hold(4'b1101, tbl[7], 10);
        check_val("glitch_count", 32'(n_valid), 32'd1);
        check_val("glitch_val", {28'd0, digit_val[7:4]}, 32'd7);

        // Multiple / no anodes selected.
        clear_counts();
        hold(4'b1100, tbl[5], 8);
        hold(4'b1111, tbl[5], 8);
        check_val("nosel_events", 32'(n_valid + n_err), 32'd0);

        // Hex letter A on digit 2.
        clear_counts();
        hold(4'b1011, 7'b0001000, 8);
`ifdef SEG7_CAPTURE_HEX_EN
        check_val("hex_val", {28'd0, digit_val[11:8]}, 32'ha);
        check_val("hex_valid", 32'(n_valid), 32'd1);
`else
        check_val("hex_err", 32'(n_err), 32'd1);
`endif

        // Reset mid-run, then a fresh full run is required.
        hold(4'b1110, tbl[9], 3);
        do_reset();
        clear_counts();
        hold(4'b1110, tbl[9], 10);
        check_val("rst_latency", 32'(first_valid), 32'd6);
        check_val("rst_count", 32'(n_valid), 32'd1);

        // Random traffic.
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(3, 0) != 0) an = ~(4'b0001 << $urandom_range(3, 0));
            else an = 4'($urandom);
            if ($urandom_range(9, 0) < 7) seg = tbl[$urandom_range(15, 0)];
            else seg = 7'($urandom);
            hold(an, seg, int'($urandom_range(8, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
